// File: rtl/mem_arb_pkg.sv
// Shared defaults, FSM state encoding and small helpers for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Words are 4-byte aligned; any set low address bit marks a misaligned access.
  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester/memory bundle of the memory arbiter; err0/err1 exist only with MEM_ARB_ALIGN_CHECK_EN.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = mem_arb_pkg::DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = mem_arb_pkg::DEFAULT_ADDR_WIDTH
);

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  done0;
  logic                  done1;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic                  err0;
  logic                  err1;
`endif

  // Requesters plus the memory model: drive requests and read data, observe the rest.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata, mem_addr, mem_wdata, mem_we
`ifdef MEM_ARB_ALIGN_CHECK_EN
    , input err0, err1
`endif
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata, mem_addr, mem_wdata, mem_we
`ifdef MEM_ARB_ALIGN_CHECK_EN
    , output err0, err1
`endif
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // One-hot winner; last = 1'b1 means requester 1 was served most recently.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01: win = 2'b01;
      2'b10: win = 2'b10;
      2'b11: begin
        if (last) begin
          win = 2'b01;
        end else begin
          win = 2'b10;
        end
      end
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one combinational-read memory between two requesters (IDLE/ACCESS/RESP).
// Build option MEM_ARB_ALIGN_CHECK_EN: misaligned requests are granted but not issued, and flag err with done.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  mem_arbiter_if.slave bus
);

  arb_state_e            state_r;
  logic                  last_r;
  logic                  op_id_r;
  logic                  op_we_r;
  logic                  op_bad_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  mem_we_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  gnt0_r;
  logic                  gnt1_r;
  logic                  done0_r;
  logic                  done1_r;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic                  err0_r;
  logic                  err1_r;
`endif

  logic [1:0]            req_s;
  logic [1:0]            win_s;
  logic                  accept_s;
  logic                  sel_id_s;
  logic                  sel_we_s;
  logic                  sel_bad_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  assign req_s = {bus.req1, bus.req0};

  rr_arbiter2 u_rr (
    .req  (req_s),
    .last (last_r),
    .win  (win_s)
  );

  assign accept_s = |win_s;
  assign sel_id_s = win_s[1];

  // Route the winning requester's command towards the latch.
  always_comb begin
    sel_we_s    = bus.we0;
    sel_addr_s  = bus.addr0;
    sel_wdata_s = bus.wdata0;
    if (sel_id_s) begin
      sel_we_s    = bus.we1;
      sel_addr_s  = bus.addr1;
      sel_wdata_s = bus.wdata1;
    end else begin
      sel_we_s    = bus.we0;
      sel_addr_s  = bus.addr0;
      sel_wdata_s = bus.wdata0;
    end
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign sel_bad_s = word_misaligned(sel_addr_s[1:0]);
`else
  assign sel_bad_s = 1'b0;
`endif

  // Access sequencer: latch on acceptance, drive memory in ACCESS, report completion in RESP.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      last_r      <= 1'b1;
      op_id_r     <= 1'b0;
      op_we_r     <= 1'b0;
      op_bad_r    <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {DATA_WIDTH{1'b0}};
      mem_we_r    <= 1'b0;
      rdata_r     <= {DATA_WIDTH{1'b0}};
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      done0_r     <= 1'b0;
      done1_r     <= 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      err0_r      <= 1'b0;
      err1_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r     <= ST_ACCESS;
            last_r      <= sel_id_s;
            op_id_r     <= sel_id_s;
            op_we_r     <= sel_we_s;
            op_bad_r    <= sel_bad_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
            mem_we_r    <= sel_we_s & ~sel_bad_s;
            gnt0_r      <= ~sel_id_s;
            gnt1_r      <= sel_id_s;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // A write commits on this edge; a read samples the memory's combinational output.
          state_r  <= ST_RESP;
          mem_we_r <= 1'b0;
          gnt0_r   <= 1'b0;
          gnt1_r   <= 1'b0;
          done0_r  <= ~op_id_r;
          done1_r  <= op_id_r;
          if (!op_we_r && !op_bad_r) begin
            rdata_r <= bus.mem_rdata;
          end
`ifdef MEM_ARB_ALIGN_CHECK_EN
          err0_r   <= op_bad_r & ~op_id_r;
          err1_r   <= op_bad_r & op_id_r;
`endif
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          done0_r <= 1'b0;
          done1_r <= 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
          err0_r  <= 1'b0;
          err1_r  <= 1'b0;
`endif
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_we_r <= 1'b0;
          gnt0_r   <= 1'b0;
          gnt1_r   <= 1'b0;
          done0_r  <= 1'b0;
          done1_r  <= 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
          err0_r   <= 1'b0;
          err1_r   <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.done0     = done0_r;
  assign bus.done1     = done1_r;
  assign bus.rdata     = rdata_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_we    = mem_we_r;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign bus.err0      = err0_r;
  assign bus.err1      = err1_r;
`endif

endmodule
